// File: rtl/layer_out_serializer_pkg.sv
// Shared types for the layer-to-layer serializer: FSM state encoding and
// the default activation word.
package fnn_ser_pkg;

    localparam int NUM_NEURONS = 30;
    localparam int DATA_WIDTH  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef logic [DATA_WIDTH-1:0] act_word_t;

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bus between the producing layer, the serializer and the consuming layer.
// The serializer takes the slave view; whoever drives the neuron outputs
// and listens to the serial burst takes the master view.
interface layer_out_serializer_if #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
);

    logic [numNeurons*dataWidth-1:0] neuron_out;
    logic [numNeurons-1:0]           neuron_outvalid;
    logic [dataWidth-1:0]            out_data;
    logic                            out_valid;
    logic                            busy;
    logic                            overrun;

    modport master (
        output neuron_out,
        output neuron_outvalid,
        input  out_data,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  neuron_out,
        input  neuron_outvalid,
        output out_data,
        output out_valid,
        output busy,
        output overrun
    );

endinterface

// File: rtl/layer_out_serializer_capture.sv
// Capture bank: one word and one mask bit per neuron. A neuron is accepted
// once per set; a repeat before the bank is handed over is dropped and
// flagged. A clear edge frees every slot and lets that edge's valids refill
// the bank without counting as repeats.
module ser_capture_bank #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] din,
    input  logic [numNeurons-1:0]           din_valid,
    input  logic                            clear,
    output logic [numNeurons*dataWidth-1:0] data_q,
    output logic                            full,
    output logic                            overrun
);

    logic [numNeurons-1:0] mask_q;
    logic [numNeurons-1:0] mask_d;
    logic [numNeurons-1:0] accept;
    logic [numNeurons-1:0] repeat_hit;

    // Decide which valids land, which are repeats, and the next mask.
    always_comb begin
        accept     = din_valid & (~mask_q | {numNeurons{clear}});
        repeat_hit = din_valid & mask_q & {numNeurons{~clear}};
        mask_d     = clear ? din_valid : (mask_q | din_valid);
    end

    assign full = &mask_q;

    // Mask and sticky overrun flag; only reset clears overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= '0;
            overrun <= 1'b0;
        end else begin
            mask_q <= mask_d;
            if (|repeat_hit) begin
                overrun <= 1'b1;
            end
        end
    end

    // Word storage; contents are meaningless until the mask bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (accept[i]) begin
                data_q[i*dataWidth +: dataWidth] <= din[i*dataWidth +: dataWidth];
            end
        end
    end

endmodule

// File: rtl/layer_out_serializer.sv
// Collects one full layer of neuron outputs and replays them as a single
// contiguous serial burst, word 0 first. The capture bank keeps filling
// while a burst shifts out; a new burst only starts from IDLE so bursts are
// always separated by at least one out_valid=0 cycle.
//
//   state | meaning
//   IDLE  | no burst in flight; waiting for the capture bank to fill
//   SHIFT | burst in flight; one word presented per cycle
module layer_out_serializer
    import fnn_ser_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int idxWidth   = $clog2(numNeurons + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    layer_out_serializer_if.slave  bus
);

    localparam logic [idxWidth-1:0] LAST_CNT = idxWidth'(numNeurons);

    ser_state_t                      state_q;
    ser_state_t                      state_d;
    logic [idxWidth-1:0]             counter_q;
    logic [idxWidth-1:0]             counter_d;
    logic [numNeurons*dataWidth-1:0] shift_q;
    logic [numNeurons*dataWidth-1:0] shift_d;
    logic [numNeurons*dataWidth-1:0] cap_data;
    logic                            cap_full;
    logic                            cap_overrun;
    logic                            transfer;
    logic                            last_word;
    logic [dataWidth-1:0]            out_data_q;
    logic [dataWidth-1:0]            out_data_d;
    logic                            out_valid_q;
    logic                            out_valid_d;
    logic                            busy_q;
    logic                            busy_d;

    ser_capture_bank #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .din       (bus.neuron_out),
        .din_valid (bus.neuron_outvalid),
        .clear     (transfer),
        .data_q    (cap_data),
        .full      (cap_full),
        .overrun   (cap_overrun)
    );

    // The counter holds how many words have been presented so far.
    assign last_word = (counter_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on a full bank from IDLE, leave SHIFT after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_full)  state_d = SHIFT;
            SHIFT:   if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next outputs: word 0 comes straight from the capture bank on transfer,
    // the remaining words are shifted down out of the shift bank.
    always_comb begin
        transfer    = 1'b0;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        counter_d   = '0;
        shift_d     = shift_q;
        case (state_q)
            IDLE: begin
                if (cap_full) begin
                    transfer    = 1'b1;
                    out_data_d  = cap_data[dataWidth-1:0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    counter_d   = idxWidth'(1);
                    shift_d     = cap_data >> dataWidth;
                end
            end
            SHIFT: begin
                if (!last_word) begin
                    out_data_d  = shift_q[dataWidth-1:0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    counter_d   = counter_q + 1'b1;
                    shift_d     = shift_q >> dataWidth;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            counter_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            counter_q   <= counter_d;
        end
    end

    // Shift bank; contents only matter while a burst is in flight.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = cap_overrun;

endmodule
